// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits LSB first, 1 stop bit, mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit after bit 7.
module uart_receiver #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] data,
   output logic       valid,
   output logic       busy,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP, WAIT_IDLE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          rxd_meta_q, rxd_s_q;
   logic          par_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxd_meta_q <= 1'b1;
         rxd_s_q    <= 1'b1;
      end else begin
         rxd_meta_q <= rxd;
         rxd_s_q    <= rxd_meta_q;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic pbad_q, pbad_d;
   logic perr_q, perr_d;
   assign par_ok     = !pbad_q;
   assign parity_err = perr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pbad_q <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         pbad_q <= pbad_d;
         perr_q <= perr_d;
      end
   end

   always_comb begin
      pbad_d = pbad_q;
      perr_d = 1'b0;
      if (state_q == PARITY && cnt_q == LAST)
         pbad_d = ^{shift_q, rxd_s_q};
      if (state_q == STOP && cnt_q == LAST)
         perr_d = pbad_q;
   end
`else
   assign par_ok     = 1'b1;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!rxd_s_q) begin
               state_d = START;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         START: begin
            if (cnt_q == HALF) begin
               cnt_d   = '0;
               state_d = rxd_s_q ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            if (cnt_q == LAST) begin
               cnt_d          = '0;
               shift_d[bit_q] = rxd_s_q;
               if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         PARITY: begin
`ifdef UART_RX_PARITY_EN
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`else
            state_d = IDLE;
`endif
         end
         STOP: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (rxd_s_q && par_ok) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  // a low stop bit may be a break: hold off until the line rises
                  ferr_d  = !rxd_s_q;
                  state_d = rxd_s_q ? IDLE : WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         WAIT_IDLE: begin
            if (rxd_s_q)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = ferr_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver at CLKS_PER_BIT=4.
module tb_uart_receiver;

   localparam int CPB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rxd = 1'b1;
   logic [7:0] data;
   logic       valid, busy, frame_err, parity_err;

   int checks = 0;
   int failures = 0;

   int vcnt = 0;
   int fecnt = 0;
   int pecnt = 0;
   int busycnt = 0;
   logic [7:0] log_q[$];

   uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .data       (data),
      .valid      (valid),
      .busy       (busy),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (valid) begin
         vcnt = vcnt + 1;
         log_q.push_back(data);
      end
      if (frame_err) fecnt = fecnt + 1;
      if (parity_err) pecnt = pecnt + 1;
      if (busy) busycnt = busycnt + 1;
   end

   task automatic send_bit(input logic b);
      rxd = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par,
                             input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
      send_bit((^b) ^ bad_par);
`else
      if (bad_par) $display("note: parity disabled, bad_par ignored");
`endif
      send_bit(stop);
      rxd = 1'b1;
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (data !== 8'h00) begin
         failures++; $display("FAIL reset_data got=%h exp=00", data);
      end
      checks++;
      if (valid !== 1'b0) begin
         failures++; $display("FAIL reset_valid got=%b exp=0", valid);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL reset_busy got=%b exp=0", busy);
      end
      checks++;
      if ({frame_err, parity_err} !== 2'b00) begin
         failures++;
         $display("FAIL reset_errs got=%b exp=00", {frame_err, parity_err});
      end
      rst = 1'b0;
      idle(4);
   endtask

   task automatic test_single;
      int v0, f0, b0;
      v0 = vcnt; f0 = fecnt; b0 = busycnt;
      send_frame(8'h61, 1'b0, 1'b1);
      idle(8);
      checks++;
      if (vcnt - v0 !== 1) begin
         failures++; $display("FAIL single_valid got=%0d exp=1", vcnt - v0);
      end
      checks++;
      if (data !== 8'h61) begin
         failures++; $display("FAIL single_data got=%h exp=61", data);
      end
      checks++;
      if (fecnt - f0 !== 0) begin
         failures++; $display("FAIL single_ferr got=%0d exp=0", fecnt - f0);
      end
      checks++;
      if (busycnt - b0 < 37 || busycnt - b0 > 41) begin
         failures++;
         $display("FAIL single_busy got=%0d exp=37..41", busycnt - b0);
      end
   endtask

   task automatic test_back_to_back;
      int v0, l0;
      v0 = vcnt; l0 = log_q.size();
      send_frame(8'h61, 1'b0, 1'b1);
      send_frame(8'hD9, 1'b0, 1'b1);
      idle(8);
      checks++;
      if (vcnt - v0 !== 2) begin
         failures++; $display("FAIL b2b_count got=%0d exp=2", vcnt - v0);
      end
      if (log_q.size() >= l0 + 2) begin
         checks++;
         if (log_q[l0] !== 8'h61) begin
            failures++; $display("FAIL b2b_first got=%h exp=61", log_q[l0]);
         end
         checks++;
         if (log_q[l0+1] !== 8'hD9) begin
            failures++; $display("FAIL b2b_second got=%h exp=D9", log_q[l0+1]);
         end
      end
   endtask

   task automatic test_glitch;
      int v0, f0, b0;
      v0 = vcnt; f0 = fecnt; b0 = busycnt;
      rxd = 1'b0;
      @(negedge clk);
      idle(12);
      checks++;
      if (busycnt - b0 < 1 || busycnt - b0 > 4) begin
         failures++; $display("FAIL glitch_start got=%0d exp=1..4", busycnt - b0);
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL glitch_idle got=%b exp=0", busy);
      end
      checks++;
      if (vcnt - v0 !== 0 || fecnt - f0 !== 0) begin
         failures++;
         $display("FAIL glitch_pulse got=%0d/%0d exp=0/0", vcnt - v0, fecnt - f0);
      end
   endtask

   task automatic test_frame_err;
      int v0, f0;
      v0 = vcnt; f0 = fecnt;
      send_frame(8'hA5, 1'b0, 1'b0);
      rxd = 1'b0;
      repeat (30) @(negedge clk);
      checks++;
      if (fecnt - f0 !== 1) begin
         failures++; $display("FAIL ferr_count got=%0d exp=1", fecnt - f0);
      end
      checks++;
      if (vcnt - v0 !== 0) begin
         failures++; $display("FAIL ferr_valid got=%0d exp=0", vcnt - v0);
      end
      checks++;
      if (data !== 8'hD9) begin
         failures++; $display("FAIL ferr_data got=%h exp=D9", data);
      end
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL ferr_wait got=%b exp=1", busy);
      end
      idle(4);
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL ferr_release got=%b exp=0", busy);
      end
   endtask

   task automatic test_reset_abort;
      int v0, f0;
      logic [7:0] b;
      b = 8'h3C;
      v0 = vcnt; f0 = fecnt;
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(b[i]);
      rxd = b[3];
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL abort_busy got=%b exp=0", busy);
      end
      @(negedge clk);
      rst = 1'b0;
      idle(16);
      checks++;
      if (vcnt - v0 !== 0 || fecnt - f0 !== 0) begin
         failures++;
         $display("FAIL abort_pulse got=%0d/%0d exp=0/0", vcnt - v0, fecnt - f0);
      end
      checks++;
      if (data !== 8'h00) begin
         failures++; $display("FAIL abort_data got=%h exp=00", data);
      end
      send_frame(8'h3C, 1'b0, 1'b1);
      idle(8);
      checks++;
      if (vcnt - v0 !== 1 || data !== 8'h3C) begin
         failures++;
         $display("FAIL abort_resume got=%0d/%h exp=1/3C", vcnt - v0, data);
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity;
      int v0, p0;
      v0 = vcnt; p0 = pecnt;
      send_frame(8'h61, 1'b0, 1'b1);
      idle(8);
      checks++;
      if (vcnt - v0 !== 1 || pecnt - p0 !== 0) begin
         failures++;
         $display("FAIL par_good got=%0d/%0d exp=1/0", vcnt - v0, pecnt - p0);
      end
      v0 = vcnt; p0 = pecnt;
      send_frame(8'h55, 1'b1, 1'b1);
      idle(8);
      checks++;
      if (vcnt - v0 !== 0 || pecnt - p0 !== 1) begin
         failures++;
         $display("FAIL par_bad got=%0d/%0d exp=0/1", vcnt - v0, pecnt - p0);
      end
      checks++;
      if (data !== 8'h61) begin
         failures++; $display("FAIL par_data got=%h exp=61", data);
      end
   endtask
`else
   task automatic test_parity;
      checks++;
      if (pecnt !== 0) begin
         failures++; $display("FAIL par_tied got=%0d exp=0", pecnt);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_glitch;
      test_frame_err;
      test_reset_abort;
      test_parity;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4, meaning clk cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port rxd, input, 1, serial line, idle high, asynchronous to clk.
REQ-005 The block SHALL have port data, output, 8, last correctly received byte.
REQ-006 The block SHALL have port valid, output, 1, one-cycle pulse when data is updated.
REQ-007 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-008 The block SHALL have port frame_err, output, 1, one-cycle pulse on stop-bit error.
REQ-009 The block SHALL have port parity_err, output, 1, one-cycle pulse on parity error (see Configuration).

Function
REQ-010 The block SHALL pass rxd through a 2-flop synchronizer (rxd_s); all decisions use rxd_s only.
REQ-011 The frame SHALL be: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-013 IDLE -> START on the first cycle with rxd_s = 0; the bit counter clears and the cycle counter loads 0.
REQ-014 START: at cycle count CLKS_PER_BIT/2 (integer division), sample rxd_s; 0 -> DATA, 1 -> IDLE (glitch rejected, no pulse).
REQ-015 DATA: sample rxd_s every CLKS_PER_BIT cycles after the start mid-point; shift the bit into position bit_index; after bit 7 -> PARITY if enabled, else STOP.
REQ-016 STOP: sample rxd_s one CLKS_PER_BIT after the last data or parity sample.
REQ-017 If the stop sample is 1 and there is no parity error, the byte SHALL be copied to data and valid pulsed for exactly one cycle; the next state is IDLE.
REQ-018 If the stop sample is 0, frame_err SHALL pulse for one cycle, data SHALL be unchanged, valid SHALL stay 0, and the next state is WAIT_IDLE.
REQ-019 WAIT_IDLE SHALL remain until rxd_s = 1, then go to IDLE (a break condition causes no repeated errors).
REQ-020 valid, frame_err and parity_err SHALL assert on the clock edge following the stop sample.
REQ-021 A new start bit SHALL be accepted in IDLE immediately after valid, supporting back-to-back frames with no extra idle bit.
REQ-022 The cycle counter SHALL be $clog2(CLKS_PER_BIT)+1 bits wide and SHALL wrap to 0 at each bit boundary.
REQ-023 rxd changes during a bit (other than at the sample point) SHALL have no effect.

Reset
REQ-024 rst high SHALL immediately force: state IDLE, data 8'h00, valid 0, busy 0, frame_err 0, parity_err 0, counters 0, both synchronizer flops 1.
REQ-025 rst asserted mid-frame SHALL abort the frame without any pulse; after release, reception restarts only on a new falling edge.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: the PARITY state is used; an even-parity bit is sampled after bit 7; a mismatch pulses parity_err with the stop-bit timing; data is not updated and valid stays 0.
REQ-027 Macro UART_RX_PARITY_EN undefined: the PARITY state is unreachable, the frame is 10 bits, and parity_err is tied to 0.

Verification
REQ-028 CLKS_PER_BIT=4, no parity, frame 0x61 -> one valid pulse, data=8'h61, frame_err=0, busy high for about 40 cycles.
REQ-029 Frame 0x61 immediately followed by 0xD9 -> two valid pulses in order, data=8'h61 then 8'hD9.
REQ-030 rxd low for 1 cycle only, in IDLE -> START then back to IDLE, no valid, no frame_err.
REQ-031 Frame 0xA5 with stop bit 0, then rxd held low 30 cycles -> a single frame_err pulse, data unchanged, FSM stays in WAIT_IDLE until rxd rises.
REQ-032 rst pulsed during data bit 3 of 0x3C, then full frame 0x3C -> no pulse from the aborted frame, one valid with data=8'h3C.
REQ-033 UART_RX_PARITY_EN, 0x61 with parity 1 (correct) -> valid; same byte with parity 0 -> parity_err pulse, no valid.
